// File: rtl/ysyx_22040750_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// ysyx_22040750_axi_sram_slave
//
// AXI4-style memory responder that sits behind the cache crossbar and serves
// icache/dcache refills and dirty-line write-backs. It handles one transaction
// at a time, using INCR bursts of 64-bit beats backed by an internal word array.
//
// Ports
//   I_clk / I_rst         clock, asynchronous active-low reset
//   AR channel            I_axi_araddr, I_axi_arvalid, O_axi_arready,
//                         I_axi_arlen, I_axi_arsize
//   R channel             O_axi_rdata, O_axi_rvalid, I_axi_rready, O_axi_rlast
//   AW channel            I_axi_awaddr, I_axi_awvalid, O_axi_awready,
//                         I_axi_awlen, I_axi_awsize
//   W channel             I_axi_wdata, I_axi_wstrb, I_axi_wvalid,
//                         O_axi_wready, I_axi_wlast
//   B channel             O_axi_bvalid, I_axi_bready
//   O_proto_err           sticky flag for size errors and wlast mismatches
// ---------------------------------------------------------------------------
module ysyx_22040750_axi_sram_slave #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          RD_DELAY   = 2
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [31:0] I_axi_araddr,
  input  logic        I_axi_arvalid,
  output logic        O_axi_arready,
  input  logic [7:0]  I_axi_arlen,
  input  logic [2:0]  I_axi_arsize,
  output logic [63:0] O_axi_rdata,
  output logic        O_axi_rvalid,
  input  logic        I_axi_rready,
  output logic        O_axi_rlast,
  input  logic [31:0] I_axi_awaddr,
  input  logic        I_axi_awvalid,
  output logic        O_axi_awready,
  input  logic [7:0]  I_axi_awlen,
  input  logic [2:0]  I_axi_awsize,
  input  logic [63:0] I_axi_wdata,
  input  logic [7:0]  I_axi_wstrb,
  input  logic        I_axi_wvalid,
  output logic        O_axi_wready,
  input  logic        I_axi_wlast,
  output logic        O_axi_bvalid,
  input  logic        I_axi_bready,
  output logic        O_proto_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // The wait counter is loaded with RD_DELAY-1 so that RD_WAIT lasts exactly
  // RD_DELAY cycles; with RD_DELAY=0 the wait state is skipped entirely.
  localparam logic [7:0] DLY_LOAD = (RD_DELAY > 0) ? 8'(RD_DELAY - 1) : 8'd0;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_WAIT,
    S_RD_BURST,
    S_WR_DATA,
    S_WR_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [7:0]            beat_q, beat_d;
  logic [7:0]            dly_q, dly_d;
  logic                  proto_err_q, proto_err_d;

  logic [63:0] mem [DEPTH];

  logic                  aw_hs, ar_hs, w_hs, r_hs, b_hs;
  logic [DEPTH_LOG2-1:0] aw_idx, ar_idx;

  // Word index is the offset from ADDR_BASE in 8-byte units. Truncating to
  // DEPTH_LOG2 bits aliases the whole space onto the array, and incrementing
  // the truncated index makes bursts wrap modulo the array depth.
  assign aw_idx = DEPTH_LOG2'((I_axi_awaddr - ADDR_BASE) >> 3);
  assign ar_idx = DEPTH_LOG2'((I_axi_araddr - ADDR_BASE) >> 3);

  // Channel ready/valid signals are decoded from the state register only. AR
  // is held off whenever AW is valid, which gives writes priority when both
  // arrive together.
  assign O_axi_awready = (state_q == S_IDLE);
  assign O_axi_arready = (state_q == S_IDLE) && !I_axi_awvalid;
  assign O_axi_wready  = (state_q == S_WR_DATA);
  assign O_axi_bvalid  = (state_q == S_WR_RESP);
  assign O_axi_rvalid  = (state_q == S_RD_BURST);
  assign O_axi_rlast   = (state_q == S_RD_BURST) && (beat_q == 8'd0);
  // Read data is gated so that it is zero outside a burst, including during
  // reset, and stays stable while the master stalls.
  assign O_axi_rdata   = (state_q == S_RD_BURST) ? mem[idx_q] : 64'd0;
  assign O_proto_err   = proto_err_q;

  assign aw_hs = I_axi_awvalid & O_axi_awready;
  assign ar_hs = I_axi_arvalid & O_axi_arready;
  assign w_hs  = I_axi_wvalid  & O_axi_wready;
  assign r_hs  = O_axi_rvalid  & I_axi_rready;
  assign b_hs  = O_axi_bvalid  & I_axi_bready;

  // Next-state logic. The beat counter holds the number of beats still to
  // transfer after the current one, so zero marks the final beat. A write
  // burst always ends on its awlen+1'th beat. A wlast that disagrees with
  // that only raises the error flag.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    dly_d       = dly_q;
    proto_err_d = proto_err_q;
    unique case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (aw_hs) begin
          idx_d   = aw_idx;
          beat_d  = I_axi_awlen;
          state_d = S_WR_DATA;
          if (I_axi_awsize != 3'd3) proto_err_d = 1'b1;
        end else if (ar_hs) begin
          idx_d   = ar_idx;
          beat_d  = I_axi_arlen;
          dly_d   = DLY_LOAD;
          state_d = (RD_DELAY == 0) ? S_RD_BURST : S_RD_WAIT;
          if (I_axi_arsize != 3'd3) proto_err_d = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (dly_q == 8'd0) state_d = S_RD_BURST;
        else               dly_d   = dly_q - 8'd1;
      end
      S_RD_BURST: begin
        if (r_hs) begin
          idx_d  = idx_q + IDX_ONE;
          beat_d = beat_q - 8'd1;
          if (beat_q == 8'd0) state_d = S_IDLE;
        end
      end
      S_WR_DATA: begin
        if (w_hs) begin
          idx_d  = idx_q + IDX_ONE;
          beat_d = beat_q - 8'd1;
          if (I_axi_wlast != (beat_q == 8'd0)) proto_err_d = 1'b1;
          if (beat_q == 8'd0) state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (b_hs) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Control registers. The asynchronous reset aborts any burst in progress.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      beat_q      <= 8'd0;
      dly_q       <= 8'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      dly_q       <= dly_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage array. It has no reset. Byte lanes are written under wstrb.
  // Because the read port is combinational, a write is visible to any read
  // that is accepted after the B response.
  always_ff @(posedge I_clk) begin
    if (w_hs) begin
      for (int k = 0; k < 8; k++) begin
        if (I_axi_wstrb[k]) mem[idx_q][8*k +: 8] <= I_axi_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040750_axi_sram_slave
//
// Directed bench for the AXI SRAM responder. Stimulus tasks push the expected
// R beats and B responses into queues. A separate monitor pops and compares
// them whenever the DUT completes a handshake, and also checks that R stays
// stable while it is stalled.
// ---------------------------------------------------------------------------
module tb_ysyx_22040750_axi_sram_slave;

  localparam int RD_DELAY = 2;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b0;
  logic [31:0] I_axi_araddr = '0;
  logic        I_axi_arvalid = 1'b0;
  logic        O_axi_arready;
  logic [7:0]  I_axi_arlen = '0;
  logic [2:0]  I_axi_arsize = 3'd3;
  logic [63:0] O_axi_rdata;
  logic        O_axi_rvalid;
  logic        I_axi_rready = 1'b1;
  logic        O_axi_rlast;
  logic [31:0] I_axi_awaddr = '0;
  logic        I_axi_awvalid = 1'b0;
  logic        O_axi_awready;
  logic [7:0]  I_axi_awlen = '0;
  logic [2:0]  I_axi_awsize = 3'd3;
  logic [63:0] I_axi_wdata = '0;
  logic [7:0]  I_axi_wstrb = '0;
  logic        I_axi_wvalid = 1'b0;
  logic        O_axi_wready;
  logic        I_axi_wlast = 1'b0;
  logic        O_axi_bvalid;
  logic        I_axi_bready = 1'b1;
  logic        O_proto_err;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } rbeat_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  rbeat_t rq[$];
  bit     bq[$];

  logic [63:0] wbeat [4];
  logic [7:0]  wstrbv [4];
  logic [63:0] rexp [4];
  logic        rr_pat [4];
  int          rr_n = 0;

  ysyx_22040750_axi_sram_slave #(
    .ADDR_BASE (32'h8000_0000),
    .DEPTH_LOG2(10),
    .RD_DELAY  (RD_DELAY)
  ) dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_axi_araddr (I_axi_araddr),
    .I_axi_arvalid(I_axi_arvalid),
    .O_axi_arready(O_axi_arready),
    .I_axi_arlen  (I_axi_arlen),
    .I_axi_arsize (I_axi_arsize),
    .O_axi_rdata  (O_axi_rdata),
    .O_axi_rvalid (O_axi_rvalid),
    .I_axi_rready (I_axi_rready),
    .O_axi_rlast  (O_axi_rlast),
    .I_axi_awaddr (I_axi_awaddr),
    .I_axi_awvalid(I_axi_awvalid),
    .O_axi_awready(O_axi_awready),
    .I_axi_awlen  (I_axi_awlen),
    .I_axi_awsize (I_axi_awsize),
    .I_axi_wdata  (I_axi_wdata),
    .I_axi_wstrb  (I_axi_wstrb),
    .I_axi_wvalid (I_axi_wvalid),
    .O_axi_wready (O_axi_wready),
    .I_axi_wlast  (I_axi_wlast),
    .O_axi_bvalid (O_axi_bvalid),
    .I_axi_bready (I_axi_bready),
    .O_proto_err  (O_proto_err)
  );

  always #5 I_clk = ~I_clk;

  // Single comparison point: counts the comparison and reports any mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  // Reports an expired wait bound as a failed comparison.
  task automatic failNow(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired or unexpected event", name);
  endtask

  // Write burst of len+1 beats taken from wbeat/wstrbv, with wlast on the
  // final beat. bvalid is expected in the cycle right after the last beat,
  // and bready is held high so that B completes on the following edge.
  task automatic applyWrite(input logic [31:0] addr, input logic [7:0] len);
    int guard;
    @(posedge I_clk); #1;
    I_axi_awaddr  = addr;
    I_axi_awlen   = len;
    I_axi_awsize  = 3'd3;
    I_axi_awvalid = 1'b1;
    guard = 0;
    @(negedge I_clk);
    while (!O_axi_awready && guard < 50) begin @(negedge I_clk); guard++; end
    if (guard >= 50) failNow("aw_ready_wait");
    @(posedge I_clk); #1;
    I_axi_awvalid = 1'b0;
    bq.push_back(1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      I_axi_wdata  = wbeat[i];
      I_axi_wstrb  = wstrbv[i];
      I_axi_wlast  = (i == int'(len));
      I_axi_wvalid = 1'b1;
      guard = 0;
      @(negedge I_clk);
      while (!O_axi_wready && guard < 50) begin @(negedge I_clk); guard++; end
      if (guard >= 50) failNow("w_ready_wait");
      @(posedge I_clk); #1;
    end
    I_axi_wvalid = 1'b0;
    I_axi_wlast  = 1'b0;
    @(negedge I_clk);
    checkOutput("bvalid_after_last_w", 64'(O_axi_bvalid), 64'd1);
    @(posedge I_clk); #1;
  endtask

  // Called just after the AR handshake edge. Measures first-beat latency,
  // drives rready from rr_pat (cycle 0 = first rvalid cycle), and counts
  // the handshakes until the burst is complete.
  task automatic waitReadBurst(input int len);
    int lat, c, hs;
    lat = 0;
    do begin
      @(negedge I_clk);
      lat++;
    end while (!O_axi_rvalid && lat < 20);
    checkOutput("rd_first_beat_latency", 64'(lat), 64'(1 + RD_DELAY));
    c  = 0;
    hs = 0;
    while (hs < len + 1 && c < 100) begin
      if (O_axi_rvalid && I_axi_rready) hs++;
      @(posedge I_clk); #1;
      c++;
      I_axi_rready = (c < rr_n) ? rr_pat[c] : 1'b1;
      @(negedge I_clk);
    end
    checkOutput("rd_handshake_count", 64'(hs), 64'(len + 1));
    checkOutput("rvalid_after_rlast", 64'(O_axi_rvalid), 64'd0);
    rr_n = 0;
    I_axi_rready = 1'b1;
  endtask

  // Read burst whose expected beats come from rexp.
  task automatic applyRead(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size);
    int guard;
    for (int i = 0; i <= int'(len); i++)
      rq.push_back('{data: rexp[i], last: (i == int'(len))});
    I_axi_rready = (rr_n > 0) ? rr_pat[0] : 1'b1;
    @(posedge I_clk); #1;
    I_axi_araddr  = addr;
    I_axi_arlen   = len;
    I_axi_arsize  = size;
    I_axi_arvalid = 1'b1;
    guard = 0;
    @(negedge I_clk);
    while (!O_axi_arready && guard < 50) begin @(negedge I_clk); guard++; end
    if (guard >= 50) failNow("ar_ready_wait");
    @(posedge I_clk); #1;
    I_axi_arvalid = 1'b0;
    I_axi_arsize  = 3'd3;
    waitReadBurst(int'(len));
  endtask

  // Monitor: scoreboard pops on R/B handshakes, plus R stability under stall.
  initial begin : monitor
    logic        stalled;
    logic [63:0] held_data;
    logic        held_last;
    rbeat_t      exp_beat;
    stalled   = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    forever begin
      @(negedge I_clk);
      if (!I_rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled && O_axi_rvalid) begin
          checkOutput("r_stall_data_hold", O_axi_rdata, held_data);
          checkOutput("r_stall_last_hold", 64'(O_axi_rlast), 64'(held_last));
        end
        if (O_axi_rvalid && I_axi_rready) begin
          if (rq.size() == 0) failNow("r_unexpected_beat");
          else begin
            exp_beat = rq.pop_front();
            checkOutput("r_data", O_axi_rdata, exp_beat.data);
            checkOutput("r_last", 64'(O_axi_rlast), 64'(exp_beat.last));
          end
        end
        stalled   = O_axi_rvalid && !I_axi_rready;
        held_data = O_axi_rdata;
        held_last = O_axi_rlast;
        if (O_axi_bvalid && I_axi_bready) begin
          checkOutput("b_expected", 64'(bq.size()), 64'd1);
          if (bq.size() > 0) void'(bq.pop_front());
        end
      end
    end
  end

  // Overall time limit so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int guard;

    // 1. Reset hold and INIT cycle.
    repeat (5) begin
      @(negedge I_clk);
      checkOutput("reset_outputs_zero",
                  {O_axi_rdata[31:0] | O_axi_rdata[63:32], 25'd0, O_axi_arready,
                   O_axi_awready, O_axi_rvalid, O_axi_rlast, O_axi_wready,
                   O_axi_bvalid, O_proto_err}, 64'd0);
    end
    @(posedge I_clk); #1;
    I_rst = 1'b1;
    @(negedge I_clk);
    checkOutput("init_readies_zero", {62'd0, O_axi_arready, O_axi_awready}, 64'd0);
    @(negedge I_clk);
    checkOutput("idle_readies_one", {62'd0, O_axi_arready, O_axi_awready}, 64'd3);
    checkOutput("idle_proto_err", 64'(O_proto_err), 64'd0);

    // 2. Two-beat write then read back with RD_DELAY latency.
    wbeat[0] = 64'h1111_1111_1111_1111; wstrbv[0] = 8'hFF;
    wbeat[1] = 64'h2222_2222_2222_2222; wstrbv[1] = 8'hFF;
    applyWrite(32'h8000_0040, 8'd1);
    rexp[0] = 64'h1111_1111_1111_1111;
    rexp[1] = 64'h2222_2222_2222_2222;
    applyRead(32'h8000_0040, 8'd1, 3'd3);

    // 3. Partial strobe over an all-ones word.
    wbeat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrbv[0] = 8'hFF;
    applyWrite(32'h8000_0000, 8'd0);
    wbeat[0] = 64'h0000_0000_1234_5678; wstrbv[0] = 8'h0F;
    applyWrite(32'h8000_0000, 8'd0);
    rexp[0] = 64'hFFFF_FFFF_1234_5678;
    applyRead(32'h8000_0000, 8'd0, 3'd3);

    // 4. AR and AW together: write wins, AR waits for the B handshake.
    rq.push_back('{data: 64'hDEAD_BEEF_CAFE_F00D, last: 1'b1});
    @(posedge I_clk); #1;
    I_axi_awaddr = 32'h8000_0080; I_axi_awlen = 8'd0; I_axi_awsize = 3'd3;
    I_axi_araddr = 32'h8000_0080; I_axi_arlen = 8'd0; I_axi_arsize = 3'd3;
    I_axi_awvalid = 1'b1;
    I_axi_arvalid = 1'b1;
    @(negedge I_clk);
    checkOutput("both_valid_awready", 64'(O_axi_awready), 64'd1);
    checkOutput("both_valid_arready", 64'(O_axi_arready), 64'd0);
    @(posedge I_clk); #1;
    I_axi_awvalid = 1'b0;
    bq.push_back(1'b1);
    I_axi_wdata = 64'hDEAD_BEEF_CAFE_F00D; I_axi_wstrb = 8'hFF;
    I_axi_wlast = 1'b1; I_axi_wvalid = 1'b1;
    @(negedge I_clk);
    checkOutput("arready_in_wr_data", 64'(O_axi_arready), 64'd0);
    @(posedge I_clk); #1;
    I_axi_wvalid = 1'b0; I_axi_wlast = 1'b0;
    @(negedge I_clk);
    checkOutput("arready_in_wr_resp", 64'(O_axi_arready), 64'd0);
    checkOutput("bvalid_simul", 64'(O_axi_bvalid), 64'd1);
    @(posedge I_clk); #1;
    @(negedge I_clk);
    checkOutput("arready_after_b", 64'(O_axi_arready), 64'd1);
    @(posedge I_clk); #1;
    I_axi_arvalid = 1'b0;
    waitReadBurst(0);

    // 5. Four-beat read with rready pattern 1,0,0,1.
    wbeat[0] = 64'hA0A0_0000_0000_0001; wstrbv[0] = 8'hFF;
    wbeat[1] = 64'hA1A1_0000_0000_0002; wstrbv[1] = 8'hFF;
    wbeat[2] = 64'hA2A2_0000_0000_0003; wstrbv[2] = 8'hFF;
    wbeat[3] = 64'hA3A3_0000_0000_0004; wstrbv[3] = 8'hFF;
    applyWrite(32'h8000_0100, 8'd3);
    for (int i = 0; i < 4; i++) rexp[i] = wbeat[i];
    rr_pat[0] = 1'b1; rr_pat[1] = 1'b0; rr_pat[2] = 1'b0; rr_pat[3] = 1'b1;
    rr_n = 4;
    applyRead(32'h8000_0100, 8'd3, 3'd3);
    checkOutput("proto_err_still_clear", 64'(O_proto_err), 64'd0);

    // 6a. Wrap from the last array word to word 0.
    wbeat[0] = 64'h5A5A_5A5A_0000_03FF; wstrbv[0] = 8'hFF;
    wbeat[1] = 64'hC3C3_C3C3_0000_0000; wstrbv[1] = 8'hFF;
    applyWrite(32'h8000_1FF8, 8'd1);
    rexp[0] = 64'h5A5A_5A5A_0000_03FF;
    rexp[1] = 64'hC3C3_C3C3_0000_0000;
    applyRead(32'h8000_1FF8, 8'd1, 3'd3);
    rexp[0] = 64'hC3C3_C3C3_0000_0000;
    applyRead(32'h8000_0000, 8'd0, 3'd3);

    // 6b. arsize=2 raises the sticky error, and the beat is still 8 bytes.
    rexp[0] = 64'h1111_1111_1111_1111;
    applyRead(32'h8000_0040, 8'd0, 3'd2);
    checkOutput("proto_err_set", 64'(O_proto_err), 64'd1);
    rexp[0] = 64'h2222_2222_2222_2222;
    applyRead(32'h8000_0048, 8'd0, 3'd3);
    checkOutput("proto_err_sticky", 64'(O_proto_err), 64'd1);

    // 6c. Reset during RD_BURST with the master stalling.
    I_axi_rready = 1'b0;
    @(posedge I_clk); #1;
    I_axi_araddr = 32'h8000_0100; I_axi_arlen = 8'd3; I_axi_arsize = 3'd3;
    I_axi_arvalid = 1'b1;
    guard = 0;
    @(negedge I_clk);
    while (!O_axi_arready && guard < 50) begin @(negedge I_clk); guard++; end
    if (guard >= 50) failNow("ar_ready_wait_reset_case");
    @(posedge I_clk); #1;
    I_axi_arvalid = 1'b0;
    repeat (RD_DELAY + 1) @(negedge I_clk);
    checkOutput("rvalid_before_reset", 64'(O_axi_rvalid), 64'd1);
    #2;
    I_rst = 1'b0;
    #1;
    checkOutput("rvalid_async_reset", 64'(O_axi_rvalid), 64'd0);
    checkOutput("proto_err_reset", 64'(O_proto_err), 64'd0);
    repeat (3) @(posedge I_clk);
    #1;
    I_rst = 1'b1;
    I_axi_rready = 1'b1;
    @(negedge I_clk);
    checkOutput("post_reset_init_arready", 64'(O_axi_arready), 64'd0);
    rexp[0] = 64'hA0A0_0000_0000_0001;
    rexp[1] = 64'hA1A1_0000_0000_0002;
    applyRead(32'h8000_0100, 8'd1, 3'd3);

    repeat (3) @(negedge I_clk);
    checkOutput("r_queue_drained", 64'(rq.size()), 64'd0);
    checkOutput("b_queue_drained", 64'(bq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040750_axi_sram_slave.md
Name: ysyx_22040750_axi_sram_slave

Overview:
AXI4-style memory responder that serves the cache top's master port: ar/r, aw/w/b channels with INCR bursts of 64-bit beats. It is backed by an internal word array. It is the simulation/FPGA memory endpoint behind the cache's icache/dcache crossbar, and handles refills and dirty-line write-backs. It processes one transaction at a time.

Parameters:
ADDR_BASE, 32'h8000_0000, byte address mapped to word 0
DEPTH_LOG2, 10, log2 of array depth in 64-bit words (1024 words)
RD_DELAY, 2, idle cycles between AR handshake and first R beat (0 allowed)

Ports:
I_clk  in  1  clock
I_rst  in  1  asynchronous reset, active-low
I_axi_araddr  in  32  read burst start byte address
I_axi_arvalid  in  1  AR valid
O_axi_arready  out  1  AR ready
I_axi_arlen  in  8  beats-1
I_axi_arsize  in  3  beat size; must be 3
O_axi_rdata  out  64  read data
O_axi_rvalid  out  1  R valid
I_axi_rready  in  1  R ready
O_axi_rlast  out  1  last read beat
I_axi_awaddr  in  32  write burst start byte address
I_axi_awvalid  in  1  AW valid
O_axi_awready  out  1  AW ready
I_axi_awlen  in  8  beats-1
I_axi_awsize  in  3  beat size; must be 3
I_axi_wdata  in  64  write data
I_axi_wstrb  in  8  byte enables
I_axi_wvalid  in  1  W valid
O_axi_wready  out  1  W ready
I_axi_wlast  in  1  last write beat
O_axi_bvalid  out  1  write response valid
I_axi_bready  in  1  B ready
O_proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (I_rst=0, async):
  - All outputs are 0.
  - State is INIT. Array contents are not reset.
  - INIT moves to IDLE on the first clock after reset deassertion.
  - Readies are therefore 0 during reset and in the first post-reset cycle.
- Word index = (addr - ADDR_BASE)[DEPTH_LOG2+2:3]. The low 3 address bits are ignored. Bursts wrap modulo 2^DEPTH_LOG2.
- States: INIT, IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_RESP.
- IDLE:
  - O_axi_awready = 1.
  - O_axi_arready = !I_axi_awvalid, so write has priority when both valids are high in the same cycle.
  - AW handshake: latch index and beat counter = awlen → WR_DATA.
  - AR handshake: latch index and beat counter = arlen → RD_WAIT, or → RD_BURST if RD_DELAY=0.
- RD_WAIT: counts RD_DELAY cycles → RD_BURST. The first rvalid appears exactly 1+RD_DELAY cycles after the AR handshake cycle.
- RD_BURST:
  - rvalid = 1 and rdata = array[index].
  - On rvalid&rready: index+1 and counter-1.
  - rlast = 1 when counter == 0. The handshake on that beat → IDLE, with rvalid=0 the next cycle.
  - rdata, rlast and rvalid stay stable while rready = 0.
- WR_DATA:
  - wready = 1.
  - On wvalid&wready, each byte k of array[index] is written with wdata[8k+7:8k] if wstrb[k]. Then index+1 and counter-1.
  - The burst ends on beat awlen+1 regardless of wlast → WR_RESP.
  - A wlast mismatch (early or missing) sets O_proto_err.
- WR_RESP: bvalid = 1 until bready → IDLE.
- Ordering: a write completed before a later AR is visible to that read, including back-to-back B then AR.
- O_proto_err is also set by arsize or awsize ≠ 3 at handshake. The transfer still proceeds with 8-byte beats. The flag clears only on reset.
- Reset mid-burst aborts immediately: valids drop to 0 and the next accept is possible after INIT.
- Only one transaction is ever outstanding. No readies are asserted outside IDLE, except wready in WR_DATA.
- Target size: about 200 lines of RTL.

Test Plan:
1. Reset hold 5 cycles, release → arready/awready are 0 through the first post-reset edge, then 1. All valids and O_proto_err stay 0.
2. Write burst:
   - AW 0x8000_0040, awlen=1, wdata 0x1111_1111_1111_1111 then 0x2222_2222_2222_2222, wstrb=FF, wlast on beat 2 → bvalid the cycle after beat 2.
   - Then AR 0x8000_0040, arlen=1, RD_DELAY=2 → first rvalid 3 cycles after the AR handshake. Beats return 0x1111…, 0x2222…, with rlast only on beat 2.
3. Partial strobe: word 0x8000_0000 preloaded with all-F, write 0x0000_0000_1234_5678 with wstrb=0F → read returns 0xFFFF_FFFF_1234_5678.
4. arvalid and awvalid asserted in the same cycle → AW accepted, arready=0 until the B handshake. AR is then accepted in IDLE and returns the just-written data.
5. Backpressure: rready toggles 1,0,0,1 during a 4-beat read → rdata/rlast hold during stalls, exactly 4 handshakes occur, no beat is duplicated.
6. Wrap, size error and mid-burst reset:
   - AR at the last array word with arlen=1 → beat 2 comes from word 0.
   - arsize=2 → O_proto_err=1, sticky.
   - Reset asserted during RD_BURST → rvalid 0 asynchronously, then normal operation after INIT.
